integral_ctrl: RTL and testbench
================================

INTEGRAL_CTRL -- requirements
Module: integral_ctrl

Interface
REQ-001 Parameter MAX_INFLIGHT, default 4: credit depth, i.e. the number of issued column pairs not yet consumed by the sink.
REQ-002 Parameter IDX_W, default 11: width of column indices.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 start  in  1  one-cycle pulse; begins a frame.
REQ-006 cfg_pairs  in  IDX_W  number of column pairs in the frame minus 1; sampled on start.
REQ-007 abort  in  1  stops issuing and drains in-flight pairs.
REQ-008 buf_rdy  in  1  FFT column buffer holds the next column pair.
REQ-009 buf_pop  out  1  consumes one pair from the buffer; equals dp_valid.
REQ-010 dp_valid  out  1  issue strobe to the magnitude-squared datapath.
REQ-011 dp_index_col_1 / dp_index_col_2  out  IDX_W each  indices of the issued pair.
REQ-012 dp_ready  in  1  datapath result strobe, fixed 3 cycles after dp_valid.
REQ-013 dp_out_index_col1  in  IDX_W  col1 index returned with the result.
REQ-014 sink_pop  in  1  downstream consumed one result; returns one credit.
REQ-015 busy  out  1  high in RUN or DRAIN.
REQ-016 done  out  1  one-cycle pulse at frame end.
REQ-017 aborted  out  1  valid with done; frame ended by abort.
REQ-018 err  out  1  sticky; returned index mismatch.

Function
REQ-019 States: IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE->RUN on start: latch cfg_pairs; clear issue count, return count, aborted and err; credits=MAX_INFLIGHT.
REQ-021 dp_valid = RUN & buf_rdy & (credits>0) & (issue_cnt<=cfg_pairs); combinational from registered state.
REQ-022 On an issue for step s: dp_index_col_1=2s, dp_index_col_2=2s+1 (mod 2^IDX_W); issue_cnt increments.
REQ-023 The index outputs are not gated by dp_valid: they always show the next step.
REQ-024 RUN->DRAIN on the cycle the final pair issues, or on abort; no issue occurs in the abort cycle.
REQ-025 Each dp_ready increments ret_cnt; each sink_pop increments credits.
REQ-026 Credit update per cycle: issue only = -1; sink_pop only = +1; both = unchanged.
REQ-027 Credits never exceed MAX_INFLIGHT; sink_pop with credits at MAX_INFLIGHT is ignored.
REQ-028 DRAIN->DONE when ret_cnt==issue_cnt and credits==MAX_INFLIGHT.
REQ-029 DONE: done=1 for one cycle, then IDLE; aborted=1 in that cycle if the frame was aborted.
REQ-030 start is ignored outside IDLE.
REQ-031 abort is ignored outside RUN.
REQ-032 cfg_pairs=0 gives a single issue, step 0 only.
REQ-033 issue_cnt and ret_cnt are IDX_W+1 bits wide; no wrap within a frame.

Reset
REQ-034 rst_n low at a clock edge: state=IDLE, counters=0, credits=MAX_INFLIGHT, err=0, aborted=0.
REQ-035 In the same reset condition all outputs read 0: dp_valid, buf_pop, done, busy, and both index outputs.
REQ-036 Reset mid-frame discards in-flight results; dp_ready after reset has no effect while in IDLE.

Configuration
REQ-037 Macro INTEGRAL_CTRL_IDXCHK_EN defined: keep a FIFO of expected col1 indices, depth MAX_INFLIGHT.
REQ-038 With the macro defined, on each dp_ready compare dp_out_index_col1 with the FIFO head; a mismatch sets err until the next start or reset.
REQ-039 With the macro defined, a dp_ready while the FIFO is empty also sets err.
REQ-040 Macro undefined: no FIFO is built and err is tied to 0.

Verification
REQ-041 Nominal frame: cfg_pairs=7, buf_rdy=1, sink_pop 3 cycles after each dp_ready -> 8 issues with col_1 indices 0,2,...,14; done 1 cycle after credits reach 4; aborted=0.
REQ-042 Credit stall: sink_pop held 0, cfg_pairs=9 -> exactly 4 issues, then dp_valid stays 0; releasing sink_pop resumes issuing; 10 issues in total.
REQ-043 Abort: abort in the cycle after the 3rd issue -> no further issue; done with aborted=1 after 3 returns and credits reach 4.
REQ-044 Simultaneous issue and sink_pop at credits=2 -> credits stay 2; start while busy -> ignored.
REQ-045 With INTEGRAL_CTRL_IDXCHK_EN, the returned index for step 2 is forced to 5 -> err=1 and stays 1 through done; it clears on the next start.
REQ-046 rst_n low for 1 cycle mid-RUN -> next cycle IDLE, busy=0, dp_valid=0; stray dp_ready pulses produce no done.

Source files
------------

// File: rtl/integral_ctrl_if.sv
// Handshake bundle between the integral controller, the FFT column buffer, the
// magnitude-squared datapath and the downstream sink.
interface integral_ctrl_if #(
  parameter int unsigned IDX_W = 11
);
  logic             start;
  logic [IDX_W-1:0] cfg_pairs;
  logic             abort;
  logic             buf_rdy;
  logic             buf_pop;
  logic             dp_valid;
  logic [IDX_W-1:0] dp_index_col_1;
  logic [IDX_W-1:0] dp_index_col_2;
  logic             dp_ready;
  logic [IDX_W-1:0] dp_out_index_col1;
  logic             sink_pop;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             err;

  modport slave (
    input  start, cfg_pairs, abort, buf_rdy, dp_ready, dp_out_index_col1, sink_pop,
    output buf_pop, dp_valid, dp_index_col_1, dp_index_col_2, busy, done, aborted, err
  );

  modport master (
    output start, cfg_pairs, abort, buf_rdy, dp_ready, dp_out_index_col1, sink_pop,
    input  buf_pop, dp_valid, dp_index_col_1, dp_index_col_2, busy, done, aborted, err
  );
endinterface

// File: rtl/integral_ctrl.sv
// Credit-limited issue controller for column-pair integration frames.
// Optional returned-index checker enabled by INTEGRAL_CTRL_IDXCHK_EN.
module integral_ctrl #(
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned IDX_W        = 11
) (
  input logic             clk,
  input logic             rst_n,
  integral_ctrl_if.slave  bus
);
  localparam int unsigned CredW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CredW-1:0] CredMax = CredW'(MAX_INFLIGHT);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] pairs_q, pairs_d;
  logic [IDX_W:0]   issue_cnt_q, issue_cnt_d;
  logic [IDX_W:0]   ret_cnt_q, ret_cnt_d;
  logic [CredW-1:0] credits_q, credits_d;
  logic             aborted_q, aborted_d;
  logic             issue, ret, frame_start;
  logic [IDX_W-1:0] next_col1;

  assign frame_start = (state_q == StIdle) && bus.start;
  // The abort cycle itself must not issue.
  assign issue = (state_q == StRun) && bus.buf_rdy && (credits_q != '0) &&
                 (issue_cnt_q <= {1'b0, pairs_q}) && !bus.abort;
  assign ret   = bus.dp_ready && (state_q != StIdle);

  assign next_col1          = issue_cnt_q[IDX_W-1:0] << 1;
  assign bus.dp_valid       = issue;
  assign bus.buf_pop        = issue;
  assign bus.dp_index_col_1 = (state_q == StIdle) ? '0 : next_col1;
  assign bus.dp_index_col_2 = (state_q == StIdle) ? '0 : (next_col1 | IDX_W'(1));
  assign bus.busy           = (state_q == StRun) || (state_q == StDrain);
  assign bus.done           = (state_q == StDone);
  assign bus.aborted        = (state_q == StDone) && aborted_q;

  always_comb begin
    state_d     = state_q;
    pairs_d     = pairs_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    credits_d   = credits_q;
    aborted_d   = aborted_q;

    // A pop in the same cycle as an issue hands the credit straight back.
    if (issue && !bus.sink_pop) begin
      credits_d = credits_q - 1'b1;
    end else if (!issue && bus.sink_pop && (credits_q != CredMax)) begin
      credits_d = credits_q + 1'b1;
    end
    if (issue) issue_cnt_d = issue_cnt_q + 1'b1;
    if (ret)   ret_cnt_d   = ret_cnt_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d     = StRun;
          pairs_d     = bus.cfg_pairs;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          credits_d   = CredMax;
          aborted_d   = 1'b0;
        end
      end
      StRun: begin
        if (bus.abort) begin
          state_d   = StDrain;
          aborted_d = 1'b1;
        end else if (issue && (issue_cnt_q == {1'b0, pairs_q})) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if ((ret_cnt_q == issue_cnt_q) && (credits_q == CredMax)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pairs_q     <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      credits_q   <= CredMax;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pairs_q     <= pairs_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      credits_q   <= credits_d;
      aborted_q   <= aborted_d;
    end
  end

`ifdef INTEGRAL_CTRL_IDXCHK_EN
  localparam int unsigned PtrW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

  logic [IDX_W-1:0] fifo_q [MAX_INFLIGHT];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CredW-1:0] fill_q;
  logic             err_q, fifo_pop, mismatch;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_pop = ret && (fill_q != '0);
  assign mismatch = ret && ((fill_q == '0) || (fifo_q[rd_ptr_q] != bus.dp_out_index_col1));

  always_ff @(posedge clk) begin
    if (issue) fifo_q[wr_ptr_q] <= next_col1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || frame_start) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (issue)    wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (fifo_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (issue && !fifo_pop)      fill_q <= fill_q + 1'b1;
      else if (!issue && fifo_pop) fill_q <= fill_q - 1'b1;
      if (mismatch) err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_ret_idx;
  assign unused_ret_idx = ^bus.dp_out_index_col1;
  assign bus.err        = 1'b0;
`endif
endmodule

// File: tb/tb_integral_ctrl.sv
// Randomised self-checking bench for integral_ctrl against a frame-level model.
module tb_integral_ctrl;
  localparam int MaxInf = 4;
`ifdef INTEGRAL_CTRL_IDXCHK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  integral_ctrl_if #(.IDX_W(11)) bus ();
  integral_ctrl #(.MAX_INFLIGHT(MaxInf), .IDX_W(11)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0, errors = 0, cyc = 0;
  bit rst_req = 1'b0;
  // Frame model: phase 0 idle, 1 run, 2 drain, 3 done.
  int m_ph = 0, m_pairs = 0, m_issued = 0, m_ret = 0, m_cred = MaxInf;
  bit m_ab = 0, m_err = 0;
  int m_fifo[$];
  // Environment: datapath returns and sink pops scheduled by cycle number.
  int rdy_cyc[$], rdy_idx[$], pop_cyc[$];
  bit sink_hold = 0;
  int force_step = -1;
  bit e_valid, e_busy, e_done, e_ab, e_err;
  int e_col1, e_col2;

  function automatic logic [27:0] obs_vec();
    return {bus.dp_valid, bus.buf_pop, bus.busy, bus.done, bus.aborted, bus.err,
            bus.dp_index_col_1, bus.dp_index_col_2};
  endfunction

  function automatic logic [27:0] exp_vec();
    logic [10:0] c1, c2;
    c1 = 11'(e_col1);
    c2 = 11'(e_col2);
    return {e_valid, e_valid, e_busy, e_done, e_ab, e_err, c1, c2};
  endfunction

  task automatic drive(input bit st, input int cfg, input bit ab, input bit rdy);
    @(negedge clk);
    rst_n = rst_req;
    bus.start = st;
    bus.cfg_pairs = 11'(cfg);
    bus.abort = ab;
    bus.buf_rdy = rdy;
    bus.dp_ready = 1'b0;
    bus.dp_out_index_col1 = '0;
    if (rdy_cyc.size() > 0 && rdy_cyc[0] <= cyc) begin
      bus.dp_ready = 1'b1;
      bus.dp_out_index_col1 = 11'(rdy_idx[0]);
      void'(rdy_cyc.pop_front());
      void'(rdy_idx.pop_front());
    end
    bus.sink_pop = 1'b0;
    if (!sink_hold && pop_cyc.size() > 0 && pop_cyc[0] <= cyc) begin
      bus.sink_pop = 1'b1;
      void'(pop_cyc.pop_front());
    end
    e_valid = (m_ph == 1) && rdy && (m_cred > 0) && (m_issued <= m_pairs) && !ab;
    e_busy  = (m_ph == 1) || (m_ph == 2);
    e_done  = (m_ph == 3);
    e_ab    = e_done && m_ab;
    e_err   = m_err;
    e_col1  = (m_ph == 0) ? 0 : (2 * m_issued) % 2048;
    e_col2  = (m_ph == 0) ? 0 : (2 * m_issued + 1) % 2048;
    #1;
  endtask

  task automatic advance();
    int col, nxt;
    bit drain_ok;
    if (!rst_n) begin
      m_ph = 0; m_issued = 0; m_ret = 0; m_cred = MaxInf; m_ab = 0; m_err = 0;
      m_fifo.delete();
    end else begin
      if (bus.dp_ready) pop_cyc.push_back(cyc + 3);
      if (m_ph == 0) begin
        if (bus.start) begin
          m_ph = 1; m_pairs = int'(bus.cfg_pairs); m_issued = 0; m_ret = 0;
          m_cred = MaxInf; m_ab = 0; m_err = 0;
          m_fifo.delete();
        end
      end else begin
        drain_ok = (m_ret == m_issued) && (m_cred == MaxInf);
        nxt = m_ph;
        if (bus.dp_ready) begin
          m_ret++;
          if (ChkEn) begin
            if (m_fifo.size() == 0) m_err = 1;
            else if (m_fifo.pop_front() != int'(bus.dp_out_index_col1)) m_err = 1;
          end
        end
        case (m_ph)
          1: if (bus.abort) begin nxt = 2; m_ab = 1; end
             else if (e_valid && m_issued == m_pairs) nxt = 2;
          2: if (drain_ok) nxt = 3;
          3: nxt = 0;
          default: ;
        endcase
        if (e_valid && !bus.sink_pop) m_cred--;
        else if (!e_valid && bus.sink_pop && m_cred < MaxInf) m_cred++;
        if (e_valid) begin
          col = (2 * m_issued) % 2048;
          rdy_cyc.push_back(cyc + 3);
          rdy_idx.push_back((m_issued == force_step) ? 5 : col);
          m_fifo.push_back(col);
          m_issued++;
        end
        m_ph = nxt;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    rst_req = 1'b0;
    drive(1'b0, 0, 1'b0, 1'b1);
    advance();
    drive(1'b0, 0, 1'b0, 1'b1);
    checks++;
    if (obs_vec() !== 28'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp %h", obs_vec(), 28'h0);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_model got %h exp %h", obs_vec(), exp_vec());
    end
    advance();
    rst_req = 1'b1;
  endtask

  task automatic test_nominal();
    int got[$];
    bit fin = 0;
    drive(1'b1, 7, 1'b0, 1'b1);
    advance();
    for (int i = 0; i < 200 && !fin; i++) begin
      drive(1'b0, 0, 1'b0, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL nominal cyc %0d got %h exp %h", cyc, obs_vec(), exp_vec());
      end
      if (bus.dp_valid) got.push_back(int'(bus.dp_index_col_1));
      if (bus.done) begin
        fin = 1;
        checks++;
        if (bus.aborted !== 1'b0) begin
          errors++;
          $display("FAIL nominal_aborted got %b exp 0", bus.aborted);
        end
      end
      advance();
    end
    checks++;
    if (!fin) begin errors++; $display("FAIL nominal_timeout got no done exp done"); end
    checks++;
    if (got.size() != 8) begin
      errors++;
      $display("FAIL nominal_count got %0d exp 8", got.size());
    end
    for (int k = 0; k < got.size(); k++) begin
      checks++;
      if (got[k] != 2 * k) begin
        errors++;
        $display("FAIL nominal_idx[%0d] got %0d exp %0d", k, got[k], 2 * k);
      end
    end
  endtask

  task automatic test_credit_stall();
    int n = 0;
    bit fin = 0;
    sink_hold = 1;
    drive(1'b1, 9, 1'b0, 1'b1);
    advance();
    for (int i = 0; i < 25; i++) begin
      drive(1'b0, 0, 1'b0, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL stall cyc %0d got %h exp %h", cyc, obs_vec(), exp_vec());
      end
      if (bus.dp_valid) n++;
      advance();
    end
    checks++;
    if (n != MaxInf) begin errors++; $display("FAIL stall_issues got %0d exp %0d", n, MaxInf); end
    sink_hold = 0;
    for (int i = 0; i < 300 && !fin; i++) begin
      drive(1'b0, 0, 1'b0, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL stall_release cyc %0d got %h exp %h", cyc, obs_vec(), exp_vec());
      end
      if (bus.dp_valid) n++;
      fin = bus.done;
      advance();
    end
    checks++;
    if (!fin || n != 10) begin
      errors++;
      $display("FAIL stall_total got %0d issues done=%b exp 10 issues done=1", n, fin);
    end
  endtask

  task automatic test_abort();
    int n = 0;
    bit fin = 0, ab_sent = 0, ab_now, ab_seen = 0;
    drive(1'b1, 9, 1'b0, 1'b1);
    advance();
    for (int i = 0; i < 200 && !fin; i++) begin
      ab_now = (n == 3) && !ab_sent;
      if (ab_now) ab_sent = 1;
      drive(1'b0, 0, ab_now, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL abort cyc %0d got %h exp %h", cyc, obs_vec(), exp_vec());
      end
      if (bus.dp_valid) n++;
      if (bus.done) begin fin = 1; ab_seen = bus.aborted; end
      advance();
    end
    checks++;
    if (!fin || n != 3 || !ab_seen) begin
      errors++;
      $display("FAIL abort_end got issues=%0d done=%b aborted=%b exp 3/1/1", n, fin, ab_seen);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int frames = 0;
    bit st;
    drive(1'b1, 3, 1'b0, 1'b1);
    advance();
    for (int i = 0; i < 300 && frames < 2; i++) begin
      // Start pulses while busy must be ignored; the idle cycle after done restarts.
      st = (i == 2) || (frames == 1 && m_ph == 0 && n == 4);
      drive(st, (frames == 0) ? 0 : 3, 1'b0, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL b2b cyc %0d got %h exp %h", cyc, obs_vec(), exp_vec());
      end
      if (bus.dp_valid) n++;
      if (bus.done) frames++;
      advance();
    end
    checks++;
    if (frames != 2 || n != 8) begin
      errors++;
      $display("FAIL b2b_total got frames=%0d issues=%0d exp 2/8", frames, n);
    end
  endtask

  task automatic test_idxchk();
    bit fin = 0;
    force_step = 2;
    drive(1'b1, 5, 1'b0, 1'b1);
    advance();
    for (int i = 0; i < 200 && !fin; i++) begin
      drive(1'b0, 0, 1'b0, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL idxchk cyc %0d got %h exp %h", cyc, obs_vec(), exp_vec());
      end
      if (bus.done) begin
        fin = 1;
        checks++;
        if (bus.err !== ChkEn) begin
          errors++;
          $display("FAIL idxchk_err_at_done got %b exp %b", bus.err, ChkEn);
        end
      end
      advance();
    end
    force_step = -1;
    drive(1'b1, 0, 1'b0, 1'b1);
    advance();
    fin = 0;
    for (int i = 0; i < 100 && !fin; i++) begin
      drive(1'b0, 0, 1'b0, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL idxchk_clear cyc %0d got %h exp %h", cyc, obs_vec(), exp_vec());
      end
      if (i == 0) begin
        checks++;
        if (bus.err !== 1'b0) begin errors++; $display("FAIL idxchk_cleared got %b exp 0", bus.err); end
      end
      fin = bus.done;
      advance();
    end
    checks++;
    if (!fin) begin errors++; $display("FAIL idxchk_timeout got no done exp done"); end
  endtask

  task automatic test_random();
    bit fin;
    for (int f = 0; f < 6; f++) begin
      fin = 0;
      drive(1'b1, (f == 0) ? 0 : int'($urandom_range(12)), 1'b0, 1'b1);
      advance();
      for (int i = 0; i < 400 && !fin; i++) begin
        if ($urandom_range(7) == 0) sink_hold = !sink_hold;
        drive($urandom_range(15) == 0, int'($urandom_range(20)), $urandom_range(39) == 0,
              $urandom_range(3) != 0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL random f%0d cyc %0d got %h exp %h", f, cyc, obs_vec(), exp_vec());
        end
        fin = bus.done;
        advance();
      end
      sink_hold = 0;
      checks++;
      if (!fin) begin errors++; $display("FAIL random_timeout f%0d got no done exp done", f); end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 9, 1'b0, 1'b1);
    advance();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 0, 1'b0, 1'b1);
      advance();
    end
    rst_req = 1'b0;
    drive(1'b0, 0, 1'b0, 1'b1);
    advance();
    rst_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 0, 1'b0, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_mid cyc %0d got %h exp %h", cyc, obs_vec(), exp_vec());
      end
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_idle got done=%b busy=%b exp 0/0", bus.done, bus.busy);
      end
      advance();
    end
    rdy_cyc.delete();
    rdy_idx.delete();
    pop_cyc.delete();
  endtask

  initial begin
    bus.start = 0; bus.cfg_pairs = '0; bus.abort = 0; bus.buf_rdy = 0;
    bus.dp_ready = 0; bus.dp_out_index_col1 = '0; bus.sink_pop = 0;
    test_reset();
    test_nominal();
    test_credit_stall();
    test_abort();
    test_back_to_back();
    test_idxchk();
    test_random();
    test_reset_mid();
    test_nominal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
